// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types, default sizes and index-width helper for the round-robin bus arbiter
package bus_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: combinational rotating priority encoder, searches last+1, last+2, ... mod N
module bus_rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest slot so the requester right after last wins
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) pick = idx;
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin sharing of one valid/ready bus master port among NUM_REQ requesters.
// Define BUS_ARB_TIMEOUT_EN to abort transactions stalled TIMEOUT_CYCLES BUSY cycles (req_err=1).
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      m_valid,
    output logic                      m_rw,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_ready,
    input  logic [DATA_W-1:0]         m_rdata,
    output logic [NUM_REQ-1:0]        grant
);

    localparam int IW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("bus_rr_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        last_q, last_d, pick;
    logic                 any, done, timeout;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 m_valid_q, m_valid_d, m_rw_q, m_rw_d;
    logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
    logic [DATA_W-1:0]    m_wdata_q, m_wdata_d;

    bus_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req  (req_valid),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = idx_w(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Count BUSY cycles without acceptance; restarts at zero on every grant
    always_comb cnt_d = (state_q == ARB_BUSY && !done) ? cnt_q + 1'b1 : '0;

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout = state_q == ARB_BUSY && !m_ready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    assign done = state_q == ARB_BUSY && (m_ready || timeout);

    // State, pointer and registered bus payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            last_q    <= IW'(NUM_REQ - 1);
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_rw_q    <= m_rw_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Leave IDLE on any request, leave BUSY on acceptance or abort
    always_comb state_d = (state_q == ARB_IDLE) ? (any ? ARB_BUSY : ARB_IDLE) : (done ? ARB_IDLE : ARB_BUSY);

    // Latch the winner's payload at grant; clear the bus back to idle values on completion
    always_comb begin
        last_d    = last_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        m_rw_d    = m_rw_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        if (state_q == ARB_IDLE && any) begin
            last_d    = pick;
            grant_d   = NUM_REQ'(1) << pick;
            m_valid_d = 1'b1;
            m_rw_d    = req_rw[pick];
            m_addr_d  = req_addr[pick*ADDR_W +: ADDR_W];
            m_wdata_d = req_wdata[pick*DATA_W +: DATA_W];
        end else if (done) begin
            grant_d   = '0;
            m_valid_d = 1'b0;
            m_rw_d    = 1'b0;
            m_addr_d  = '0;
            m_wdata_d = '0;
        end
    end

    // Completion handshake returned to the current owner in the accept/abort cycle
    always_comb begin
        req_ready = done ? grant_q : '0;
        req_err   = timeout;
    end

    assign req_rdata = m_rdata;
    assign m_valid   = m_valid_q;
    assign m_rw      = m_rw_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: vector table plus corner sequences with a grant scoreboard for bus_rr_arbiter
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_rw, req_ready, grant;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata, m_wdata, m_rdata;
    logic [AW-1:0]   m_addr;
    logic            req_err, m_valid, m_rw, m_ready;

    int total = 0;
    int bad   = 0;
    int last_m = N - 1;

    typedef struct {
        logic [N-1:0]  grant;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    typedef struct {
        int            idx;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            delay;
        logic [DW-1:0] rdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    bus_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .m_valid   (m_valid),
        .m_rw      (m_rw),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] oh(input int p);
        return N'(1) << p;
    endfunction

    function automatic int rr_model(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_rw[i]            = rw;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Model the next arbitration decision from the current requests and push what the bus must show
    task automatic push_pick();
        int p;
        p = rr_model(req_valid, last_m);
        last_m = p;
        sb.push_back('{oh(p), req_rw[p], req_addr[p*AW +: AW], req_wdata[p*DW +: DW]});
    endtask

    // Wait for m_valid (bounded), then pop and compare the bus against the scoreboard
    task automatic wait_grant();
        int lat;
        exp_t e;
        lat = 0;
        while (!m_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("grant_latency", 64'(lat), 64'(1));
        if (m_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant", 64'(grant), 64'(e.grant));
            chk("m_addr", 64'(m_addr), 64'(e.addr));
            chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
            chk("m_rw", 64'(m_rw), 64'(e.rw));
        end else begin
            total++;
            bad++;
            $display("FAIL wait_grant: m_valid=%0b queued=%0d", m_valid, sb.size());
        end
    endtask

    // Accept in this cycle, check the handshake, then check the bus has gone idle
    task automatic finish_txn(input logic [N-1:0] g, input logic rw, input logic [DW-1:0] rd);
        m_ready = 1'b1;
        m_rdata = rd;
        #1;
        chk("done_m_valid", 64'(m_valid), 64'(1));
        chk("req_ready", 64'(req_ready), 64'(g));
        chk("req_err", 64'(req_err), 64'(0));
        if (!rw) chk("req_rdata", 64'(req_rdata), 64'(rd));
        @(negedge clk);
        m_ready = 1'b0;
        req_valid = req_valid & ~g;
        chk("idle_m_valid", 64'(m_valid), 64'(0));
        chk("idle_grant", 64'(grant), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        vecs[0] = '{2, 1'b1, 32'h10,   32'hA5,       2, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h44,   32'h0,        0, 32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 32'h1000, 32'h12345678, 1, 32'h0};
        vecs[3] = '{3, 1'b0, 32'hFFFC, 32'h0,        3, 32'hCAFEF00D};
        vecs[4] = '{2, 1'b0, 32'h8,    32'h0,        0, 32'h0000_0001};
        vecs[5] = '{0, 1'b1, 32'h4,    32'hFFFFFFFF, 1, 32'h0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_m_addr", 64'(m_addr), 64'(0));
        chk("rst_m_wdata", 64'(m_wdata), 64'(0));
        chk("rst_m_rw", 64'(m_rw), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_req_err", 64'(req_err), 64'(0));
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("idle_ignores_m_ready", 64'(req_ready), 64'(0));
        m_ready = 1'b0;

        // Single-requester table
        foreach (vecs[v]) begin
            set_req(vecs[v].idx, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            push_pick();
            wait_grant();
            for (int c = 0; c < vecs[v].delay; c++) begin
                chk("hold_req_ready", 64'(req_ready), 64'(0));
                @(negedge clk);
                chk("hold_m_valid", 64'(m_valid), 64'(1));
            end
            finish_txn(oh(vecs[v].idx), vecs[v].rw, vecs[v].rdata);
        end

        // Payload latched at grant: later address change is not seen on the bus
        set_req(2, 1'b1, 32'h20, 32'h55);
        push_pick();
        wait_grant();
        req_addr[2*AW +: AW] = 32'h30;
        repeat (3) begin
            @(negedge clk);
            chk("latched_addr", 64'(m_addr), 64'(32'h20));
        end
        finish_txn(oh(2), 1'b1, 32'h0);

        // Reset mid-transaction drops the bus at once and restores the pointer
        set_req(0, 1'b1, 32'hA0, 32'h77);
        push_pick();
        wait_grant();
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'(0));
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_m = N - 1;
        set_req(3, 1'b1, 32'hB0, 32'h88);
        push_pick();
        wait_grant();
        finish_txn(oh(0), 1'b1, 32'h0);
        push_pick();
        wait_grant();
        finish_txn(oh(3), 1'b1, 32'h0);

        // All requesting with m_ready tied high: grants rotate every other cycle
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(32'h100 + i), DW'(32'h5A00 + i));
        m_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            push_pick();
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rr_grant", 64'(grant), 64'(e.grant));
                chk("rr_m_addr", 64'(m_addr), 64'(e.addr));
                chk("rr_req_ready", 64'(req_ready), 64'(e.grant));
            end
            @(negedge clk);
            chk("rr_gap_m_valid", 64'(m_valid), 64'(0));
        end
        req_valid = '0;
        m_ready = 1'b0;
        @(negedge clk);

`ifdef BUS_ARB_TIMEOUT_EN
        // Stalled target: abort with req_err on the TO-th BUSY cycle
        set_req(1, 1'b1, 32'hC0, 32'h99);
        push_pick();
        wait_grant();
        for (int k = 1; k < TO; k++) begin
            chk("to_wait_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        chk("to_req_ready", 64'(req_ready), 64'(oh(1)));
        chk("to_req_err", 64'(req_err), 64'(1));
        @(negedge clk);
        req_valid = '0;
        chk("to_m_valid", 64'(m_valid), 64'(0));
        @(negedge clk);
        // Acceptance in the final timeout cycle completes normally
        set_req(2, 1'b1, 32'hC4, 32'h9A);
        push_pick();
        wait_grant();
        repeat (TO - 1) @(negedge clk);
        finish_txn(oh(2), 1'b1, 32'h0);
`else
        // No timeout: a stalled target keeps the bus indefinitely
        set_req(1, 1'b1, 32'hC0, 32'h99);
        push_pick();
        wait_grant();
        repeat (TO + 4) @(negedge clk);
        chk("stall_m_valid", 64'(m_valid), 64'(1));
        chk("stall_req_ready", 64'(req_ready), 64'(0));
        chk("stall_req_err", 64'(req_err), 64'(0));
        finish_txn(oh(1), 1'b1, 32'h0);
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
